// File: rtl/reaction_pkg.sv
// Shared constants for the reaction-game timer: FSM state codes, BCD limits
// and the prescaler divide ratio.
package reaction_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] RUN    = 2'b01;
  localparam logic [1:0] COMMIT = 2'b10;
  localparam logic [1:0] HOLD   = 2'b11;

  localparam logic [3:0] BCD_NINE = 4'd9;

  function automatic int tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the reaction counter; ripples a carry to the next digit on 9->0.
module bcd_digit_counter
  import reaction_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc_in,
  output logic [3:0] digit,
  output logic       carry_out
);

  assign carry_out = inc_in && (digit == BCD_NINE);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      digit <= 4'd0;
    end else if (inc_in) begin
      digit <= (digit == BCD_NINE) ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/reaction_bcd_timer.sv
// Reaction timer: counts BCD ticks while enabled, commits the lowest valid time
// as best, and drives either current or best time to the 7-seg decoders.
module reaction_bcd_timer
  import reaction_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int DIGITS  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                count_en,
  input  logic                complete,
  input  logic                show_best,
  input  logic                clear_best,
  output logic [4*DIGITS-1:0] display,
  output logic [4*DIGITS-1:0] best,
  output logic                best_valid,
  output logic                new_best,
  output logic                overflow
);

  localparam int TDIV = tick_div(CLK_HZ, TICK_HZ);
  localparam int PW   = (TDIV > 2) ? $clog2(TDIV) : 1;
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{BCD_NINE}};

  logic [1:0]          state;
  logic [PW-1:0]       prescaler;
  logic [4*DIGITS-1:0] count;
  logic [DIGITS:0]     carry;
  logic                tick;
  logic                all_nine;
  logic                run_stay;
  logic                commit_win;
  logic                unused_top_carry;

  assign tick     = (state == RUN) && (prescaler == PW'(TDIV - 1));
  assign all_nine = (count == ALL_NINES);
  assign run_stay = (state == RUN) && count_en && !complete;

  // Saturate by withholding the tick from digit 0 once every digit reads 9.
  assign carry[0]         = tick && !all_nine;
  assign unused_top_carry = carry[DIGITS];

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit_counter u_digit (
        .clock     (clock),
        .reset     (reset),
        .clr       (state == IDLE),
        .inc_in    (carry[i]),
        .digit     (count[4*i +: 4]),
        .carry_out (carry[i+1])
      );
    end
  endgenerate

  // Packed BCD orders the same as unsigned binary since every nibble is 0..9.
  assign commit_win = (state == COMMIT) && !overflow && (!best_valid || (count < best));

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      prescaler  <= '0;
      best       <= ALL_NINES;
      best_valid <= 1'b0;
      new_best   <= 1'b0;
      overflow   <= 1'b0;
      display    <= '0;
    end else begin
      new_best  <= 1'b0;
      display   <= show_best ? best : count;
      prescaler <= (run_stay && !tick) ? prescaler + 1'b1 : '0;

      case (state)
        IDLE: begin
          overflow <= 1'b0;
          if (count_en) state <= RUN;
        end
        RUN: begin
          if (tick && all_nine) overflow <= 1'b1;
          if (complete)       state <= COMMIT;
          else if (!count_en) state <= IDLE;
        end
        COMMIT: state <= HOLD;
        HOLD: begin
          // A new round always passes through IDLE so the count is cleared first.
          if (!complete) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (clear_best) begin
        best       <= ALL_NINES;
        best_valid <= 1'b0;
      end else if (commit_win) begin
        best       <= count;
        best_valid <= 1'b1;
        new_best   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reaction_bcd_timer.sv
// Bench for reaction_bcd_timer: a 4-digit and a 2-digit build share stimulus and
// are checked every cycle against an integer-arithmetic round model.
module tb_reaction_bcd_timer;

  localparam int TD = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        count_en = 1'b0;
  logic        complete = 1'b0;
  logic        show_best = 1'b0;
  logic        clear_best = 1'b0;

  logic [15:0] d4_display, d4_best;
  logic        d4_best_valid, d4_new_best, d4_overflow;
  logic [7:0]  d2_display, d2_best;
  logic        d2_best_valid, d2_new_best, d2_overflow;

  int n_checks = 0;
  int n_errors = 0;
  int pulses[2];

  reaction_bcd_timer #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(4)) dut4 (
    .clock(clock), .reset(reset), .count_en(count_en), .complete(complete),
    .show_best(show_best), .clear_best(clear_best), .display(d4_display),
    .best(d4_best), .best_valid(d4_best_valid), .new_best(d4_new_best),
    .overflow(d4_overflow)
  );

  reaction_bcd_timer #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2)) dut2 (
    .clock(clock), .reset(reset), .count_en(count_en), .complete(complete),
    .show_best(show_best), .clear_best(clear_best), .display(d2_display),
    .best(d2_best), .best_valid(d2_best_valid), .new_best(d2_new_best),
    .overflow(d2_overflow)
  );

  always #5 clock = ~clock;

  // Round-level model: time = RUN cycles / TD, saturating at the digit limit.
  typedef enum int {PH_IDLE, PH_RUN, PH_COMMIT, PH_HOLD} phase_e;
  phase_e m_phase[2];
  int     m_cycles[2], m_count[2], m_best[2], m_disp[2];
  bit     m_ovf[2], m_bvalid[2], m_nb[2];
  int     m_max[2] = '{9999, 99};

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int          x;
    r = '0;
    x = v;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit upd;
      int ticks;
      if (reset) begin
        m_phase[i] = PH_IDLE; m_cycles[i] = 0; m_count[i] = 0; m_best[i] = m_max[i];
        m_bvalid[i] = 0; m_nb[i] = 0; m_ovf[i] = 0; m_disp[i] = 0;
      end else begin
        m_disp[i] = show_best ? m_best[i] : m_count[i];
        upd = (m_phase[i] == PH_COMMIT) && !m_ovf[i] && (!m_bvalid[i] || m_count[i] < m_best[i]);
        m_nb[i] = 0;
        case (m_phase[i])
          PH_IDLE: begin
            m_cycles[i] = 0; m_count[i] = 0; m_ovf[i] = 0;
            if (count_en) m_phase[i] = PH_RUN;
          end
          PH_RUN: begin
            m_cycles[i]++;
            ticks = m_cycles[i] / TD;
            m_count[i] = (ticks > m_max[i]) ? m_max[i] : ticks;
            m_ovf[i] = (ticks > m_max[i]);
            if (complete)       m_phase[i] = PH_COMMIT;
            else if (!count_en) m_phase[i] = PH_IDLE;
          end
          PH_COMMIT: m_phase[i] = PH_HOLD;
          default:   if (!complete) m_phase[i] = PH_IDLE;
        endcase
        if (clear_best) begin
          m_best[i] = m_max[i]; m_bvalid[i] = 0;
        end else if (upd) begin
          m_best[i] = m_count[i]; m_bvalid[i] = 1; m_nb[i] = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("d4_display",    {16'd0, d4_display},  to_bcd(m_disp[0]));
    check("d4_best",       {16'd0, d4_best},     to_bcd(m_best[0]));
    check("d4_best_valid", {31'd0, d4_best_valid}, {31'd0, m_bvalid[0]});
    check("d4_new_best",   {31'd0, d4_new_best},   {31'd0, m_nb[0]});
    check("d4_overflow",   {31'd0, d4_overflow},   {31'd0, m_ovf[0]});
    check("d2_display",    {24'd0, d2_display},  to_bcd(m_disp[1]));
    check("d2_best",       {24'd0, d2_best},     to_bcd(m_best[1]));
    check("d2_best_valid", {31'd0, d2_best_valid}, {31'd0, m_bvalid[1]});
    check("d2_new_best",   {31'd0, d2_new_best},   {31'd0, m_nb[1]});
    check("d2_overflow",   {31'd0, d2_overflow},   {31'd0, m_ovf[1]});
  endtask

  task automatic cycle(input bit r, input bit e, input bit c, input bit s, input bit b);
    reset = r; count_en = e; complete = c; show_best = s; clear_best = b;
    @(posedge clock);
    model_step();
    #1;
    compare_all();
    if (d4_new_best) pulses[0]++;
    if (d2_new_best) pulses[1]++;
  endtask

  // n enable cycles, then either an abort or done_len cycles of complete.
  task automatic round(input int n, input bit abort_it, input int done_len, input bit sb, input int cb_at);
    pulses[0] = 0; pulses[1] = 0;
    for (int i = 0; i < n; i++) cycle(0, 1, 0, sb, 0);
    if (abort_it) cycle(0, 0, 0, sb, 0);
    else for (int k = 0; k < done_len; k++) cycle(0, 1, 1, sb, k == cb_at);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("rst_display", {16'd0, d4_display}, 32'h0);
    check("rst_best", {16'd0, d4_best}, 32'h9999);
    check("rst_valid", {31'd0, d4_best_valid}, 32'd0);
    idle(2);

    round(125, 0, 3, 0, -1);
    check("r1_display", {16'd0, d4_display}, 32'h0012);
    check("r1_best", {16'd0, d4_best}, 32'h0012);
    check("r1_valid", {31'd0, d4_best_valid}, 32'd1);
    check("r1_pulses", pulses[0], 32'd1);
    idle(2);

    round(55, 0, 3, 0, -1);
    check("r2_best", {16'd0, d4_best}, 32'h0005);
    check("r2_pulses", pulses[0], 32'd1);
    idle(2);

    round(200, 0, 3, 0, -1);
    check("r3_display", {16'd0, d4_display}, 32'h0020);
    check("r3_best", {16'd0, d4_best}, 32'h0005);
    check("r3_pulses", pulses[0], 32'd0);
    idle(2);

    round(1000, 0, 3, 0, -1);
    check("r4_display4", {16'd0, d4_display}, 32'h0100);
    check("r4_display2", {24'd0, d2_display}, 32'h99);
    check("r4_ovf2", {31'd0, d2_overflow}, 32'd1);
    check("r4_ovf4", {31'd0, d4_overflow}, 32'd0);
    check("r4_best2", {24'd0, d2_best}, 32'h05);
    check("r4_pulses2", pulses[1], 32'd0);
    idle(2);

    round(75, 1, 0, 0, -1);
    idle(3);
    check("abort_display", {16'd0, d4_display}, 32'h0);
    check("abort_best", {16'd0, d4_best}, 32'h0005);
    check("abort_pulses", pulses[0], 32'd0);

    round(90, 0, 3, 0, -1);
    cycle(0, 0, 1, 1, 0);
    check("sb_on", {16'd0, d4_display}, 32'h0005);
    cycle(0, 0, 1, 0, 0);
    check("sb_off", {16'd0, d4_display}, 32'h0009);
    idle(2);

    round(20, 0, 3, 0, 1);
    check("clr_best", {16'd0, d4_best}, 32'h9999);
    check("clr_valid", {31'd0, d4_best_valid}, 32'd0);
    check("clr_pulses", pulses[0], 32'd0);
    idle(2);

    round(25, 0, 3, 0, -1);
    idle(2);
    for (int i = 0; i < 35; i++) cycle(0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("mid_rst_display", {16'd0, d4_display}, 32'h0);
    check("mid_rst_best", {16'd0, d4_best}, 32'h9999);
    check("mid_rst_valid", {31'd0, d4_best_valid}, 32'd0);
    check("mid_rst_ovf", {31'd0, d4_overflow}, 32'd0);
    check("mid_rst_best2", {24'd0, d2_best}, 32'h99);

    for (int r = 0; r < 25; r++) begin
      round($urandom_range(1, 400), ($urandom_range(0, 4) == 0),
            $urandom_range(2, 4), $urandom_range(0, 1),
            ($urandom_range(0, 5) == 0) ? 1 : -1);
      idle($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
